// File: rtl/conv1d_layer_par.sv
// Streaming 1-D convolution with run-time loadable taps, P saturating MAC lanes and a buffered valid/ready result port.
// Build option: define RELU_EN to clamp negative lane results to zero before they are buffered.
module conv1d_layer_par #(
    parameter int WIDTH = 8,
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int P     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data_in_f,
    input  logic             s_valid_f,
    output logic             s_ready_f,
    input  logic [WIDTH-1:0] s_data_in_x,
    input  logic             s_valid_x,
    output logic             s_ready_x,
    output logic [WIDTH-1:0] m_data_out_y,
    output logic             m_valid_y,
    input  logic             m_ready_y
);

    localparam int LENY = LENX - LENF + 1;
    localparam int CW   = $clog2(LENX + 1);
    localparam int XW   = $clog2(LENX);
    localparam int FW   = $clog2(LENF);
    localparam int GW   = $clog2(LENY + P + 1);
    localparam int OW   = (P > 1) ? $clog2(P) : 1;

    typedef logic signed [WIDTH-1:0] sdata_t;
    typedef enum logic [2:0] {WAIT, LOAD_F, LOAD_X, COMPUTE, OUT} state_t;

    localparam sdata_t SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam sdata_t SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic sdata_t sat_mul(input sdata_t a, input sdata_t b);
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        if (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){p[2*WIDTH-1]}})
            return p[2*WIDTH-1] ? SMIN : SMAX;
        return p[WIDTH-1:0];
    endfunction

    function automatic sdata_t sat_add(input sdata_t a, input sdata_t b);
        logic signed [WIDTH:0] s;
        s = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        if (s[WIDTH] != s[WIDTH-1])
            return s[WIDTH] ? SMIN : SMAX;
        return s[WIDTH-1:0];
    endfunction

    state_t        state_q, state_d;
    logic          started_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] g_q, g_d;
    logic [OW-1:0] o_q, o_d, last_o;
    logic          m_valid_q, m_valid_d;
    sdata_t        m_data_q, m_data_d;

    sdata_t f_q [LENF];
    sdata_t x_q [LENX];
    sdata_t fr_q;
    sdata_t xr_q     [P];
    sdata_t acc_q    [P];
    sdata_t buf_q    [P];
    sdata_t lane_sum [P];
    sdata_t lane_res [P];
    logic   lane_ok  [P];
    logic [XW-1:0] x_idx [P];
    logic [FW-1:0] f_idx;

    logic f_fire, x_fire, y_fire;

    assign s_ready_f    = (state_q == LOAD_F);
    assign s_ready_x    = (state_q == LOAD_X);
    assign m_valid_y    = m_valid_q;
    assign m_data_out_y = m_data_q;

    assign f_fire = s_valid_f && s_ready_f;
    assign x_fire = s_valid_x && s_ready_x;
    assign y_fire = m_valid_q && m_ready_y;

    // Lane datapath: operand addresses for the next read, and the accumulate result of the current tap.
    always_comb begin
        f_idx = (int'(cnt_q) < LENF) ? FW'(cnt_q) : '0;
        for (int i = 0; i < P; i++) begin
            lane_ok[i]  = (int'(g_q) + i) < LENY;
            x_idx[i]    = (int'(g_q) + i + int'(cnt_q) < LENX) ? XW'(int'(g_q) + i + int'(cnt_q)) : '0;
            lane_sum[i] = sat_add(acc_q[i], sat_mul(xr_q[i], fr_q));
            lane_res[i] = lane_sum[i];
`ifdef RELU_EN
            if (lane_sum[i][WIDTH-1]) lane_res[i] = '0;
`endif
        end
    end

    always_comb begin
        if (LENY - int'(g_q) >= P) last_o = OW'(P - 1);
        else                       last_o = OW'(LENY - int'(g_q) - 1);
    end

    // NOTE: every signal driven here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        g_d       = g_q;
        o_d       = o_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        case (state_q)
            WAIT: begin
                if (started_q) state_d = LOAD_F;
            end
            LOAD_F: begin
                if (f_fire) begin
                    if (cnt_q == CW'(LENF - 1)) begin
                        cnt_d   = '0;
                        state_d = LOAD_X;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_X: begin
                if (x_fire) begin
                    if (cnt_q == CW'(LENX - 1)) begin
                        cnt_d   = '0;
                        g_d     = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            COMPUTE: begin
                // Cycle 0 only fetches operands; cycles 1..LENF each fold in one tap.
                if (cnt_q == CW'(LENF)) begin
                    cnt_d     = '0;
                    o_d       = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = lane_res[0];
                    state_d   = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (y_fire) begin
                    if (o_q == last_o) begin
                        m_valid_d = 1'b0;
                        g_d       = g_q + GW'(P);
                        state_d   = (int'(g_q) + P < LENY) ? COMPUTE : LOAD_X;
                    end else begin
                        o_d      = o_q + OW'(1);
                        m_data_d = buf_q[o_q + OW'(1)];
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= WAIT;
            started_q <= 1'b0;
            cnt_q     <= '0;
            g_q       <= '0;
            o_q       <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            cnt_q     <= cnt_d;
            g_q       <= g_d;
            o_q       <= o_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fr_q  <= '0;
            xr_q  <= '{default: '0};
            acc_q <= '{default: '0};
            buf_q <= '{default: '0};
        end else if (state_q == COMPUTE) begin
            fr_q <= f_q[f_idx];
            for (int i = 0; i < P; i++) begin
                xr_q[i]  <= x_q[x_idx[i]];
                acc_q[i] <= (cnt_q == '0) ? '0 : lane_sum[i];
                if (cnt_q == CW'(LENF) && lane_ok[i]) buf_q[i] <= lane_res[i];
            end
        end
    end

    // NOTE: tap and sample storage is not reset; the FSM never reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (f_fire) f_q[FW'(cnt_q)] <= s_data_in_f;
        if (x_fire) x_q[XW'(cnt_q)] <= s_data_in_x;
    end

endmodule

// File: tb/tb_conv1d_layer_par.sv
// Bench for conv1d_layer_par: table of filter/input vectors, expected results queued and compared as the DUT emits them.
module tb_conv1d_layer_par;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s_data_in_f, s_data_in_x, m_data_out_y;
    logic       s_valid_f, s_ready_f, s_valid_x, s_ready_x, m_valid_y, m_ready_y;

    conv1d_layer_par #(.WIDTH(8), .LENX(8), .LENF(4), .P(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_f  (s_data_in_f),
        .s_valid_f    (s_valid_f),
        .s_ready_f    (s_ready_f),
        .s_data_in_x  (s_data_in_x),
        .s_valid_x    (s_valid_x),
        .s_ready_x    (s_ready_x),
        .m_data_out_y (m_data_out_y),
        .m_valid_y    (m_valid_y),
        .m_ready_y    (m_ready_y)
    );

    always #5 clk = ~clk;

`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct packed {
        logic            rst;
        logic            loadf;
        logic            gappy;
        logic            bp;
        logic [0:3][7:0] f;
        logic [0:7][7:0] x;
        logic [0:4][7:0] yp;
        logic [0:4][7:0] yr;
    } vec_t;

    localparam logic [0:3][7:0] F_ONES  = {8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [0:3][7:0] F_SATP  = {8'h7F, 8'h7F, 8'h00, 8'h00};
    localparam logic [0:3][7:0] F_SATN  = {8'h80, 8'h80, 8'h00, 8'h00};
    localparam logic [0:3][7:0] F_NEG1  = {8'hFF, 8'h00, 8'h00, 8'h00};
    localparam logic [0:3][7:0] F_TWO   = {8'd2, 8'h00, 8'h00, 8'h00};
    localparam logic [0:7][7:0] X_UP    = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    localparam logic [0:7][7:0] X_DN    = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [0:7][7:0] X_MAX   = {8{8'h7F}};
    localparam logic [0:4][7:0] Y_UP    = {8'd10, 8'd14, 8'd18, 8'd22, 8'd26};
    localparam logic [0:4][7:0] Y_DN    = {8'd26, 8'd22, 8'd18, 8'd14, 8'd10};
    localparam logic [0:4][7:0] Y_MAX   = {5{8'h7F}};
    localparam logic [0:4][7:0] Y_MIN   = {5{8'h80}};
    localparam logic [0:4][7:0] Y_ZERO  = {5{8'h00}};
    localparam logic [0:4][7:0] Y_NEG   = {8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB};
    localparam logic [0:4][7:0] Y_TWO   = {8'd2, 8'd4, 8'd6, 8'd8, 8'd10};

    vec_t       vecs [8];
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_err    = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b0;
        s_valid_f = 1'b0;
        s_valid_x = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic push(input bit to_f, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        if (to_f) begin s_valid_f = 1'b1; s_data_in_f = d; end
        else      begin s_valid_x = 1'b1; s_data_in_x = d; end
        while (!(to_f ? s_ready_f : s_ready_x) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", to_f ? s_ready_f : s_ready_x, 1);
    endtask

    // One whole vector: optional reset and filter load, samples, then drain all five results.
    task automatic run_vec(input int vi, input vec_t v);
        int         fi = 0, xi = 0, yn = 0, cyc = 0, lastx = -100, firstv = -1;
        int         stall = 0, hold_err = 0, rf_err = 0, cur = 0, gcode = 0;
        logic       vprev = 1'b0, prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        logic [7:0] e;
        if (v.rst) apply_reset();
        for (int k = 0; k < 5; k++) exp_q.push_back(RELU ? v.yr[k] : v.yp[k]);
        while (yn < 5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (v.loadf && fi < 4) begin s_valid_f = 1'b1; s_data_in_f = v.f[fi]; end
            else if (!v.loadf)     begin s_valid_f = 1'b1; s_data_in_f = 8'h55; end
            else                         s_valid_f = 1'b0;
            if (s_valid_f && s_ready_f) fi++;
            if (!v.loadf && s_ready_f) rf_err++;
            if (xi < 8 && (!v.gappy || (cyc % 2 == 0))) begin
                s_valid_x   = 1'b1;
                s_data_in_x = v.x[xi];
            end else begin
                s_valid_x = 1'b0;
            end
            if (s_valid_x && s_ready_x) begin
                xi++;
                if (xi == 8) lastx = cyc;
            end
            if (m_valid_y && !vprev) stall = v.bp ? 10 : 0;
            m_ready_y = (stall == 0);
            if (stall > 0) stall--;
            if (prev_stall && (!m_valid_y || m_data_out_y !== prev_data)) hold_err++;
            prev_stall = m_valid_y && !m_ready_y;
            prev_data  = m_data_out_y;
            if (m_valid_y && firstv < 0) firstv = cyc;
            if (vprev && !m_valid_y) begin
                gcode = gcode * 10 + cur;
                cur   = 0;
            end
            if (m_valid_y && m_ready_y) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else                  e = 8'hxx;
                check($sformatf("v%0d_y%0d", vi, yn), $signed(m_data_out_y), $signed(e));
                yn++;
                cur++;
            end
            vprev = m_valid_y;
        end
        gcode = gcode * 10 + cur;
        check($sformatf("v%0d_done", vi), yn, 5);
        check($sformatf("v%0d_sb_left", vi), exp_q.size(), 0);
        check($sformatf("v%0d_latency", vi), firstv - lastx, 6);
        check($sformatf("v%0d_groups", vi), gcode, 221);
        if (v.bp) check($sformatf("v%0d_hold", vi), hold_err, 0);
        if (!v.loadf) check($sformatf("v%0d_ready_f", vi), rf_err, 0);
        s_valid_f = 1'b0;
        s_valid_x = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_ready_x_next", vi), s_ready_x, 1);
    endtask

    initial begin
        reset       = 1'b0;
        s_valid_f   = 1'b0;
        s_valid_x   = 1'b0;
        s_data_in_f = '0;
        s_data_in_x = '0;
        m_ready_y   = 1'b1;

        vecs[0] = '{rst:1'b1, loadf:1'b1, gappy:1'b0, bp:1'b0, f:F_ONES, x:X_UP,  yp:Y_UP,  yr:Y_UP};
        vecs[1] = '{rst:1'b1, loadf:1'b1, gappy:1'b0, bp:1'b0, f:F_SATP, x:X_MAX, yp:Y_MAX, yr:Y_MAX};
        vecs[2] = '{rst:1'b1, loadf:1'b1, gappy:1'b0, bp:1'b0, f:F_SATN, x:X_MAX, yp:Y_MIN, yr:Y_ZERO};
        vecs[3] = '{rst:1'b1, loadf:1'b1, gappy:1'b0, bp:1'b0, f:F_NEG1, x:X_UP,  yp:Y_NEG, yr:Y_ZERO};
        vecs[4] = '{rst:1'b1, loadf:1'b1, gappy:1'b0, bp:1'b1, f:F_ONES, x:X_UP,  yp:Y_UP,  yr:Y_UP};
        vecs[5] = '{rst:1'b1, loadf:1'b1, gappy:1'b1, bp:1'b0, f:F_ONES, x:X_UP,  yp:Y_UP,  yr:Y_UP};
        vecs[6] = '{rst:1'b0, loadf:1'b0, gappy:1'b1, bp:1'b0, f:F_ONES, x:X_DN,  yp:Y_DN,  yr:Y_DN};
        vecs[7] = '{rst:1'b0, loadf:1'b1, gappy:1'b0, bp:1'b0, f:F_TWO,  x:X_UP,  yp:Y_TWO, yr:Y_TWO};

        repeat (2) @(negedge clk);
        check("rst_valid_y", m_valid_y, 0);
        check("rst_data_y",  m_data_out_y, 0);
        check("rst_ready_f", s_ready_f, 0);
        check("rst_ready_x", s_ready_x, 0);
        reset = 1'b1;

        for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

        // Reset while group 1 is computing, then a fresh filter load without another reset.
        apply_reset();
        m_ready_y = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b1, F_ONES[k]);
        for (int k = 0; k < 8; k++) push(1'b0, X_UP[k]);
        begin
            int n = 0;
            @(negedge clk);
            s_valid_f = 1'b0;
            s_valid_x = 1'b0;
            while (!m_valid_y && n < 50) begin @(negedge clk); n++; end
            check("mid_grp0_valid", m_valid_y, 1);
            while (m_valid_y && n < 100) begin @(negedge clk); n++; end
            check("mid_grp1_compute", m_valid_y, 0);
            check("mid_data_before", m_data_out_y, 14);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_valid_y", m_valid_y, 0);
        check("mid_rst_data_y",  m_data_out_y, 0);
        check("mid_rst_ready_f", s_ready_f, 0);
        check("mid_rst_ready_x", s_ready_x, 0);
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_hold_data", m_data_out_y, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_edge1_ready_f", s_ready_f, 0);
        @(negedge clk);
        check("rel_edge2_ready_f", s_ready_f, 1);
        run_vec(7, vecs[7]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/conv1d_layer_par.md
# conv1d_layer_par

Parametrised successor to the fixed-size convolution layer: a streaming 1-D convolution engine with run-time loadable filter taps, P parallel saturating MAC lanes, a configurable input length and an output buffer with valid/ready backpressure. It accepts a filter vector and then one or more input vectors over separate valid/ready slave ports. For each input vector it emits LENY = LENX-LENF+1 results on a master valid/ready port. It sits at the same position in the layer pipeline as the existing fixed-ROM layers.

## Interface
- WIDTH, 8: data width of x, f and y; signed two's complement.
- LENX, 8: input vector length, ≥ LENF.
- LENF, 4: filter length, ≥ 2.
- P, 2: number of parallel MAC lanes, 1..LENY.
- clk  in  1: clock, all logic on rising edge.
- reset  in  1: asynchronous, active-low reset.
- s_data_in_f  in  WIDTH: filter tap data.
- s_valid_f  in  1 / s_ready_f  out  1: filter handshake.
- s_data_in_x  in  WIDTH: input sample data.
- s_valid_x  in  1 / s_ready_x  out  1: input handshake.
- m_data_out_y  out  WIDTH: result data.
- m_valid_y  out  1 / m_ready_y  in  1: result handshake.

## Operation
- Transfer rule: a transfer occurs on any edge where valid && ready are both high.
- States: WAIT, LOAD_F, LOAD_X, COMPUTE, OUT.
- WAIT: entered by reset; lasts one cycle, then LOAD_F.
- LOAD_F:
  - s_ready_f=1; accepts exactly LENF taps, tap k into f[k].
  - After the LENF-th transfer, go to LOAD_X.
- LOAD_X:
  - s_ready_x=1; accepts exactly LENX samples into x[0..LENX-1].
  - Gaps in s_valid_x are allowed.
  - After the last transfer, go to COMPUTE with group base g=0.
- COMPUTE:
  - Lanes i=0..P-1 compute y[g+i] = Σk x[g+i+k]·f[k].
- Arithmetic:
  - Full 2·WIDTH signed product, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Then added to the WIDTH-bit accumulator, with the sum saturated to the same range.
  - Saturation is applied per tap, in tap order k=0..LENF-1.
- COMPUTE → OUT: lane results are latched into a P-entry output buffer; go to OUT.
- Last group: lanes with g+i ≥ LENY are invalid; they are not stored or emitted.
- OUT:
  - Buffer entries are emitted in lane order, one per transfer.
  - After the last valid entry transfers: g += P. If g < LENY go to COMPUTE, else go to LOAD_X.
- Filter persistence: the filter persists across input vectors. Only reset returns the block to LOAD_F.
- Readies outside their state: s_ready_f and s_ready_x are 0 outside LOAD_F / LOAD_X respectively. Valid asserted in other states is ignored with no transfer.

## Timing
- Reset values (held while reset=0): state=WAIT, s_ready_f=0, s_ready_x=0, m_valid_y=0, m_data_out_y=0, accumulators 0, g=0.
- After reset release:
  - s_ready_f rises after the second rising edge.
  - One WAIT cycle, then LOAD_F.
- Reset mid-operation: asserting reset in any state immediately (asynchronously) forces all outputs to their reset values. Filter contents are discarded, and a full filter reload is required.
- COMPUTE duration is LENF+1 cycles: one-cycle x-buffer read latency, then LENF accumulate cycles.
- Latency, cycle numbering: last x transfer at edge t; COMPUTE occupies cycles t+1..t+LENF+1.
- Latency, first output: m_valid_y=1 with y[0] from cycle t+LENF+2.
- Output hold: m_data_out_y and m_valid_y are registered. While m_valid_y && !m_ready_y, both are held stable.
- Output throughput: with m_ready_y held high, one result per cycle within a group. m_valid_y drops for the LENF+1 COMPUTE cycles between groups.
- Next vector: after the final y transfer, s_ready_x=1 in the next cycle. Input of the next vector does not overlap output of the current one.
- Simultaneity: s_valid_f and s_valid_x may both be high; only the port of the current state transfers.

## Configuration
- RELU_EN defined:
  - Each saturated lane result below 0 is replaced by 0 before buffering.
  - m_data_out_y is never negative.
- RELU_EN undefined: the signed saturated result is emitted unchanged.
- Timing is identical in both builds.

## Test plan
All scenarios use WIDTH=8, LENX=8, LENF=4, P=2 (LENY=5).
- Basic sum: f={1,1,1,1}, x=1..8, m_ready_y=1
  - y=10,14,18,22,26, exactly 5 transfers.
  - First m_valid_y 6 cycles after the last x transfer.
  - s_ready_x=1 the cycle after y[4] transfers.
- Saturation: f={127,127,0,0}, x all 127 → each y=127.
  - Then f reloaded via reset as {-128,-128,0,0} with x all 127.
  - Without RELU_EN: y=-128 ×5. With RELU_EN: y=0 ×5.
- ReLU: f={-1,0,0,0}, x=1..8.
  - Without RELU_EN: y=-1,-2,-3,-4,-5.
  - With RELU_EN: y=0 ×5.
- Backpressure, partial group:
  - Stimulus: basic-sum stimulus, m_ready_y low for 10 cycles at each m_valid_y rise.
  - Data held stable and the same 5 values emitted in order.
  - Third group emits 1 value only.
- Irregular input, filter persistence:
  - Stimulus: s_valid_x toggled 1/0 each cycle; vector x=1..8 then x=8..1 with no reload.
  - y=10,14,18,22,26 then 26,22,18,14,10.
  - s_ready_f stays 0 throughout.
- Reset mid-COMPUTE:
  - Stimulus: reset=0 for 2 cycles during group 1.
  - m_valid_y=0 and m_data_out_y=0 immediately.
  - s_ready_f=1 after the second rising edge following release.
  - A new filter {2,0,0,0} with x=1..8 gives y=2,4,6,8,10.
